// File: rtl/lm07_sample_scheduler_if.sv
// Host/reader signal bundle for the LM07 sample scheduler.
// The master view belongs to the scheduler; the slave view is the host plus the SPI reader.
`timescale 1ns/1ps
interface lm07_sample_scheduler_if;
    logic        ENABLE;
    logic [15:0] INTERVAL;
    logic        REQ;
    logic        RD_BUSY;
    logic        RD_DONE;
    logic [7:0]  RD_DATA;
    logic [7:0]  HI_LIMIT;
    logic [7:0]  LO_LIMIT;
    logic        RD_START;
    logic [7:0]  TEMP;
    logic        TEMP_VALID;
    logic        ACK;
    logic        ERR;
    logic        ALERT_HI;
    logic        ALERT_LO;
    logic [15:0] SAMPLE_CNT;

    modport master (
        input  ENABLE, INTERVAL, REQ, RD_BUSY, RD_DONE, RD_DATA, HI_LIMIT, LO_LIMIT,
        output RD_START, TEMP, TEMP_VALID, ACK, ERR, ALERT_HI, ALERT_LO, SAMPLE_CNT
    );

    modport slave (
        output ENABLE, INTERVAL, REQ, RD_BUSY, RD_DONE, RD_DATA, HI_LIMIT, LO_LIMIT,
        input  RD_START, TEMP, TEMP_VALID, ACK, ERR, ALERT_HI, ALERT_LO, SAMPLE_CNT
    );
endinterface

// File: rtl/lm07_sample_scheduler.sv
// Merges periodic and on-demand temperature reads onto one SPI reader; latches results and alarms.
// REQ to RD_START in 2 cycles, RD_DONE to results in 1; waits for RD_BUSY low and coalesces repeat requests.
`timescale 1ns/1ps
module lm07_sample_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int HYST    = 2
) (
    input  logic                          SYSCLK,
    input  logic                          RST,
    lm07_sample_scheduler_if.master       bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Abandon on the edge where the counter would become TIMEOUT-1.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 2);
    localparam logic signed [8:0] HYST9 = 9'(HYST);

    state_t         state, state_nxt;
    logic           req_pend, per_pend, served_req;
    logic [15:0]    intv_cnt, intv_reload;
    logic [TW-1:0]  to_cnt;
    logic           launch, done_ok, done_to;
    logic signed [8:0] t_s, hi_s, lo_s, hi_clr, lo_clr;

    always_ff @(posedge SYSCLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        case (state)
            IDLE: begin
                if ((req_pend || per_pend) && !bus.RD_BUSY) begin
                    state_nxt = ISSUE;
                    launch    = 1'b1;
                end
            end
            ISSUE: state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.RD_DONE) begin
                    done_ok   = 1'b1;
                    state_nxt = IDLE;
                end else if (to_cnt == TO_LAST) begin
                    done_to   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.RD_START = (state == ISSUE);
    assign intv_reload  = (bus.INTERVAL == 16'd0) ? 16'd0 : bus.INTERVAL - 16'd1;

    // Sign-extend to 9 bits so limit +/- HYST cannot wrap.
    assign t_s    = {bus.RD_DATA[7], bus.RD_DATA};
    assign hi_s   = {bus.HI_LIMIT[7], bus.HI_LIMIT};
    assign lo_s   = {bus.LO_LIMIT[7], bus.LO_LIMIT};
    assign hi_clr = hi_s - HYST9;
    assign lo_clr = lo_s + HYST9;

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            intv_cnt       <= '0;
            per_pend       <= 1'b0;
            req_pend       <= 1'b0;
            served_req     <= 1'b0;
            to_cnt         <= '0;
            bus.TEMP       <= '0;
            bus.TEMP_VALID <= 1'b0;
            bus.ACK        <= 1'b0;
            bus.ERR        <= 1'b0;
            bus.ALERT_HI   <= 1'b0;
            bus.ALERT_LO   <= 1'b0;
            bus.SAMPLE_CNT <= '0;
        end else begin
            bus.ACK <= 1'b0;
            bus.ERR <= 1'b0;

            // A periodic tick landing in the launch cycle stays pending for the next frame.
            if (!bus.ENABLE) begin
                intv_cnt <= '0;
                per_pend <= 1'b0;
            end else if (intv_cnt == 16'd0) begin
                per_pend <= 1'b1;
                intv_cnt <= intv_reload;
            end else begin
                intv_cnt <= intv_cnt - 16'd1;
                if (launch) per_pend <= 1'b0;
            end

            if (launch) begin
                served_req <= req_pend;
                req_pend   <= bus.REQ;
            end else if (bus.REQ) begin
                req_pend <= 1'b1;
            end

            if (state == ISSUE)          to_cnt <= '0;
            else if (state == WAIT_DONE) to_cnt <= to_cnt + 1'b1;

            if (done_ok) begin
                bus.TEMP       <= bus.RD_DATA;
                bus.TEMP_VALID <= 1'b1;
                bus.SAMPLE_CNT <= bus.SAMPLE_CNT + 16'd1;
                bus.ACK        <= served_req;
                if (t_s > hi_s)        bus.ALERT_HI <= 1'b1;
                else if (t_s < hi_clr) bus.ALERT_HI <= 1'b0;
                if (t_s < lo_s)        bus.ALERT_LO <= 1'b1;
                else if (t_s > lo_clr) bus.ALERT_LO <= 1'b0;
            end

            if (done_to) begin
                bus.ERR <= 1'b1;
                bus.ACK <= served_req;
            end
        end
    end
endmodule

// File: tb/tb_lm07_sample_scheduler.sv
// Directed bench for lm07_sample_scheduler: behavioural SPI reader, alarm vector table, multi-cycle sequences.
`timescale 1ns/1ps
module tb_lm07_sample_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lm07_sample_scheduler_if bus();

    lm07_sample_scheduler #(.TIMEOUT(64), .HYST(2)) dut (
        .SYSCLK (clk),
        .RST    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] data;
        logic       exp_hi;
        logic       exp_lo;
    } vec_t;

    vec_t vecs[16];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_start = 0, n_ack = 0, n_err = 0;
    int rd_lat;
    logic [7:0] rd_val;
    logic rd_hang;
    int exp_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.RD_START === 1'b1) n_start <= n_start + 1;
        if (bus.ACK === 1'b1)      n_ack   <= n_ack + 1;
        if (bus.ERR === 1'b1)      n_err   <= n_err + 1;
    end

    // Reader: busy from RD_START, RD_DONE with data rd_lat cycles later, idle the cycle after.
    initial begin
        bus.RD_BUSY = 1'b0;
        bus.RD_DONE = 1'b0;
        bus.RD_DATA = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (bus.RD_START === 1'b1 && !rd_hang) begin
                bus.RD_BUSY = 1'b1;
                repeat (rd_lat) begin @(posedge clk); #1; end
                bus.RD_DONE = 1'b1;
                bus.RD_DATA = rd_val;
                @(posedge clk); #1;
                bus.RD_DONE = 1'b0;
                bus.RD_BUSY = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_req(input int n);
        bus.REQ = 1'b1;
        repeat (n) tick();
        bus.REQ = 1'b0;
    endtask

    // which: 0 = RD_START, 1 = ACK, 2 = ERR. Returns -1 if the budget expires.
    task automatic wait_evt(input int which, input int budget, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            hit = (which == 0) ? bus.RD_START : (which == 1) ? bus.ACK : bus.ERR;
            if (hit === 1'b1) begin
                at = cyc;
                return;
            end
        end
    endtask

    initial begin
        int c0, s, s2, a, e, snap_s, snap_a, snap_e;

        vecs[0]  = '{8'd40,    8'(-10),  8'd41,    1'b1, 1'b0};
        vecs[1]  = '{8'd40,    8'(-10),  8'd39,    1'b1, 1'b0};
        vecs[2]  = '{8'd40,    8'(-10),  8'd37,    1'b0, 1'b0};
        vecs[3]  = '{8'd40,    8'(-10),  8'(-11),  1'b0, 1'b1};
        vecs[4]  = '{8'd40,    8'(-10),  8'(-9),   1'b0, 1'b1};
        vecs[5]  = '{8'd40,    8'(-10),  8'(-7),   1'b0, 1'b0};
        vecs[6]  = '{8'd40,    8'(-10),  8'd40,    1'b0, 1'b0};
        vecs[7]  = '{8'd40,    8'(-10),  8'd41,    1'b1, 1'b0};
        vecs[8]  = '{8'd40,    8'(-10),  8'd38,    1'b1, 1'b0};
        vecs[9]  = '{8'd127,   8'(-128), 8'd127,   1'b1, 1'b0};
        vecs[10] = '{8'(-128), 8'(-128), 8'(-128), 1'b1, 1'b0};
        vecs[11] = '{8'd127,   8'd127,   8'd126,   1'b1, 1'b1};
        vecs[12] = '{8'd127,   8'd127,   8'd127,   1'b1, 1'b1};
        vecs[13] = '{8'd40,    8'(-10),  8'd0,     1'b0, 1'b0};
        vecs[14] = '{8'(-128), 8'(-10),  8'(-127), 1'b1, 1'b1};
        vecs[15] = '{8'(-128), 8'(-10),  8'(-128), 1'b1, 1'b1};

        rst = 1'b1;
        bus.ENABLE = 1'b0;
        bus.INTERVAL = 16'd0;
        bus.REQ = 1'b0;
        bus.HI_LIMIT = 8'd40;
        bus.LO_LIMIT = 8'(-10);
        rd_lat = 12;
        rd_val = 8'h19;
        rd_hang = 1'b0;
        exp_cnt = 0;

        // Reset
        repeat (3) tick();
        check("rst_rd_start",   32'(bus.RD_START),   0);
        check("rst_temp",       32'(bus.TEMP),       0);
        check("rst_temp_valid", 32'(bus.TEMP_VALID), 0);
        check("rst_ack",        32'(bus.ACK),        0);
        check("rst_err",        32'(bus.ERR),        0);
        check("rst_alert_hi",   32'(bus.ALERT_HI),   0);
        check("rst_alert_lo",   32'(bus.ALERT_LO),   0);
        check("rst_sample_cnt", 32'(bus.SAMPLE_CNT), 0);
        rst = 1'b0;
        snap_s = n_start;
        repeat (20) tick();
        check("idle_no_start", 32'(n_start - snap_s), 0);

        // On-demand read
        snap_s = n_start;
        c0 = cyc;
        pulse_req(1);
        wait_evt(0, 10, s);
        check("req_latency", 32'(s - c0), 2);
        wait_evt(1, 40, a);
        check("done_latency", 32'(a - s), 13);
        check("od_temp",       32'(bus.TEMP),       32'h19);
        check("od_temp_valid", 32'(bus.TEMP_VALID), 1);
        exp_cnt = 1;
        check("od_sample_cnt", 32'(bus.SAMPLE_CNT), 32'(exp_cnt));
        check("od_alert_hi",   32'(bus.ALERT_HI),   0);
        tick();
        check("od_ack_one_cycle", 32'(bus.ACK), 0);
        check("od_one_frame", 32'(n_start - snap_s), 1);

        // Alarm table
        rd_lat = 2;
        for (int i = 0; i < 16; i++) begin
            bus.HI_LIMIT = vecs[i].hi;
            bus.LO_LIMIT = vecs[i].lo;
            rd_val = vecs[i].data;
            pulse_req(1);
            wait_evt(1, 20, a);
            exp_cnt++;
            check($sformatf("vec%0d_ack", i),      32'(a >= 0), 1);
            check($sformatf("vec%0d_alert_hi", i), 32'(bus.ALERT_HI), 32'(vecs[i].exp_hi));
            check($sformatf("vec%0d_alert_lo", i), 32'(bus.ALERT_LO), 32'(vecs[i].exp_lo));
            check($sformatf("vec%0d_temp", i),     32'(bus.TEMP), 32'(vecs[i].data));
            check($sformatf("vec%0d_cnt", i),      32'(bus.SAMPLE_CNT), 32'(exp_cnt));
            repeat (2) tick();
        end
        bus.HI_LIMIT = 8'd40;
        bus.LO_LIMIT = 8'(-10);

        // Periodic sampling
        rd_lat = 20;
        rd_val = 8'd20;
        snap_a = n_ack;
        bus.INTERVAL = 16'd100;
        c0 = cyc;
        bus.ENABLE = 1'b1;
        wait_evt(0, 10, s);
        check("per_first_start", 32'(s - c0), 2);
        for (int k = 1; k < 5; k++) begin
            wait_evt(0, 150, s2);
            check($sformatf("per_spacing%0d", k), 32'(s2 - s), 100);
            s = s2;
        end
        repeat (22) tick();
        exp_cnt += 5;
        check("per_sample_cnt", 32'(bus.SAMPLE_CNT), 32'(exp_cnt));
        check("per_no_ack", 32'(n_ack - snap_a), 0);
        bus.ENABLE = 1'b0;
        snap_s = n_start;
        repeat (150) tick();
        check("per_disabled", 32'(n_start - snap_s), 0);

        // Coalescing while a frame is in flight
        rd_lat = 40;
        rd_val = 8'd55;
        snap_s = n_start;
        snap_a = n_ack;
        pulse_req(1);
        wait_evt(0, 10, s);
        repeat (3) tick();
        bus.REQ = 1'b1;
        repeat (30) tick();
        bus.REQ = 1'b0;
        wait_evt(1, 40, a);
        check("coal_first_ack", 32'(a - s), 41);
        wait_evt(0, 10, s2);
        check("coal_second_start", 32'(s2 - s), 42);
        repeat (60) tick();
        check("coal_starts", 32'(n_start - snap_s), 2);
        check("coal_acks",   32'(n_ack - snap_a), 2);
        exp_cnt += 2;
        check("coal_cnt", 32'(bus.SAMPLE_CNT), 32'(exp_cnt));

        // REQ still high in the launch cycle stays pending
        rd_lat = 3;
        snap_s = n_start;
        snap_a = n_ack;
        pulse_req(2);
        repeat (30) tick();
        check("launch_req_starts", 32'(n_start - snap_s), 2);
        check("launch_req_acks",   32'(n_ack - snap_a), 2);
        exp_cnt += 2;

        // Timeout
        rd_hang = 1'b1;
        pulse_req(1);
        wait_evt(0, 10, s);
        wait_evt(2, 100, e);
        check("to_err_latency", 32'(e - s), 64);
        check("to_ack",         32'(bus.ACK), 1);
        check("to_temp_held",   32'(bus.TEMP), 55);
        check("to_cnt_held",    32'(bus.SAMPLE_CNT), 32'(exp_cnt));
        tick();
        check("to_err_one_cycle", 32'(bus.ERR), 0);
        rd_hang = 1'b0;
        rd_lat = 4;
        rd_val = 8'd33;
        pulse_req(1);
        wait_evt(1, 30, a);
        exp_cnt++;
        check("to_retry_temp", 32'(bus.TEMP), 33);
        check("to_retry_cnt",  32'(bus.SAMPLE_CNT), 32'(exp_cnt));

        // Reset during WAIT_DONE
        rd_hang = 1'b1;
        pulse_req(1);
        wait_evt(0, 10, s);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("midrst_temp",       32'(bus.TEMP), 0);
        check("midrst_temp_valid", 32'(bus.TEMP_VALID), 0);
        check("midrst_cnt",        32'(bus.SAMPLE_CNT), 0);
        check("midrst_alert_hi",   32'(bus.ALERT_HI), 0);
        rst = 1'b0;
        snap_s = n_start;
        snap_a = n_ack;
        snap_e = n_err;
        repeat (100) tick();
        check("midrst_no_err",   32'(n_err - snap_e), 0);
        check("midrst_no_ack",   32'(n_ack - snap_a), 0);
        check("midrst_no_start", 32'(n_start - snap_s), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lm07_sample_scheduler.md
# lm07_sample_scheduler

Sequencing controller for the LM07 SPI temperature-read datapath. Issues read frames to the reader at a programmable periodic interval and on host demand, merging the two request sources onto the single serial resource. Latches each returned temperature, tracks high/low alarm thresholds with hysteresis, and flags reads that never complete. Sits between system control logic and the SPI reader that drives CS/SCK/SIO.

## Interface
- `TIMEOUT`, 64: maximum cycles spent in WAIT_DONE before a read is abandoned.
- `HYST`, 2: alarm hysteresis, in degrees (LSBs of temperature).
- `SYSCLK` in 1: system clock. All logic is on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `ENABLE` in 1: enables periodic sampling.
- `INTERVAL` in 16: cycles between periodic sample requests. A value of 0 is treated as 1.
- `REQ` in 1: on-demand sample request. Level-sampled each cycle.
- `RD_BUSY` in 1: reader frame in progress.
- `RD_DONE` in 1: one-cycle pulse; `RD_DATA` is valid in that cycle.
- `RD_DATA` in 8: temperature from the reader, signed two's complement.
- `HI_LIMIT` in 8: high alarm threshold, signed.
- `LO_LIMIT` in 8: low alarm threshold, signed.
- `RD_START` out 1: one-cycle pulse that starts one reader frame.
- `TEMP` out 8: last valid temperature.
- `TEMP_VALID` out 1: sticky; set by the first successful sample.
- `ACK` out 1: one-cycle pulse when a frame serving an on-demand request ends, whether it succeeded or timed out.
- `ERR` out 1: one-cycle pulse on read timeout.
- `ALERT_HI`, `ALERT_LO` out 1: threshold alarms.
- `SAMPLE_CNT` out 16: count of successful samples; wraps modulo 2^16.

## Operation
- **Interval counter (16-bit)**
  - When `ENABLE`=0, the counter is forced to 0 and the periodic pending flag is cleared.
  - When `ENABLE`=1 and the counter is 0: set the periodic pending flag and reload with max(`INTERVAL`,1)-1.
  - Otherwise the counter decrements.
- **Pending flags**
  - `REQ`=1 sets the request pending flag.
  - Repeated requests while a flag is already set coalesce into one.
- **FSM states:** IDLE, ISSUE, WAIT_DONE.
  - IDLE → ISSUE when any pending flag is set and `RD_BUSY`=0.
    - Both flags are captured into "served" bits and cleared at this transition.
    - A `REQ` arriving in that same cycle stays pending for the next frame.
  - ISSUE: `RD_START`=1 for exactly this cycle; always → WAIT_DONE.
  - WAIT_DONE: the timeout counter is cleared on entry and increments every cycle.
    - `RD_DONE`=1 → IDLE (success).
    - Counter reaches `TIMEOUT`-1 with no `RD_DONE` → IDLE (timeout).
    - Requests arriving during WAIT_DONE are held pending; they are never merged into the frame in flight.
- **On success**
  - `TEMP` ← `RD_DATA`, `TEMP_VALID` ← 1, `SAMPLE_CNT` increments.
  - `ACK` pulses if the request was served by this frame.
- **On timeout**
  - `ERR` pulses; `TEMP`, the alarms and `SAMPLE_CNT` are unchanged.
  - `ACK` pulses if the request was served by this frame.
  - The served request is not retried.
- `RD_DONE` outside WAIT_DONE is ignored.
- **Alarms** are updated only on success, using a 9-bit signed compare to avoid overflow. With new value t:
  - `ALERT_HI` is set if t > `HI_LIMIT`, cleared if t < `HI_LIMIT`-`HYST`, otherwise held.
  - `ALERT_LO` is set if t < `LO_LIMIT`, cleared if t > `LO_LIMIT`+`HYST`, otherwise held.

## Timing
- **Reset values** (`RST`=1 at an edge): all outputs 0; FSM in IDLE; all counters and flags 0.
  - `RST` mid-frame abandons the frame with no `ERR` and no `ACK`.
- **Request latency:** `REQ` high in cycle n → pending flag set in n+1 → ISSUE (`RD_START`=1) in n+2, provided `RD_BUSY`=0 in n+1.
- **Completion latency:** `RD_DONE` in cycle m → `TEMP`, `TEMP_VALID`, alarms, `SAMPLE_CNT`, `ACK` all updated/asserted in m+1, with the FSM in IDLE.
- **Throughput:** minimum frame spacing is 3 cycles (IDLE, ISSUE, WAIT_DONE with immediate `RD_DONE`).
- **Periodic start:** after `ENABLE` rises with the counter at 0, the periodic pending flag is set in the next cycle. `INTERVAL`=N gives one periodic request every N cycles regardless of frame duration; excess requests coalesce.
- **Timeout:** `ERR` asserts exactly `TIMEOUT` cycles after the `RD_START` cycle, followed by IDLE.

## Test plan
- **Reset:** assert `RST` 3 cycles → every output 0; no `RD_START` for 20 cycles with `ENABLE`=0, `REQ`=0.
- **On-demand read:** `REQ` pulse at cycle 10, reader model returns 8'h19 (25) after 12 cycles.
  - `RD_START` at cycle 12.
  - `TEMP`=25, `TEMP_VALID`=1, `ACK` pulse, `SAMPLE_CNT`=1.
- **Periodic read:** `ENABLE`=1, `INTERVAL`=100, reader latency 20.
  - `RD_START` every 100 cycles.
  - `SAMPLE_CNT`=5 after 5 frames; `ACK` never asserts.
- **Coalescing:** `REQ` held high for 30 cycles while a frame is in flight → exactly one extra frame after completion and one `ACK` per served frame.
- **Alarms**, with `HI_LIMIT`=40, `LO_LIMIT`=-10, `HYST`=2:
  - Samples 41 / 39 / 37 → `ALERT_HI` goes 1, 1, 0.
  - Samples -11 / -9 / -7 → `ALERT_LO` goes 1, 1, 0.
- **Timeout and reset:**
  - Reader never pulses `RD_DONE` → `ERR` 64 cycles after `RD_START`; `TEMP` unchanged; next request still served.
  - `RST` in WAIT_DONE → outputs 0 and no `ERR`.
